// File: rtl/spi_device_fifo.sv
// Oversampled SPI slave with TX/RX FIFOs and valid/ready user handshakes.
// sck/ssn/mosi are synchronised into wb_clk_i; all four CPOL/CPHA modes are supported.
module spi_device_fifo #(
  parameter int unsigned WORD_W      = 8,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned CPOL        = 0,
  parameter int unsigned CPHA        = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                              wb_clk_i,
  input  logic                              wb_rst_i,
  input  logic                              sck,
  input  logic                              ssn,
  input  logic                              mosi,
  output logic                              miso,
  output logic                              miso_oeb,
  input  logic [WORD_W-1:0]                 tx_data,
  input  logic                              tx_valid,
  output logic                              tx_ready,
  output logic [WORD_W-1:0]                 rx_data,
  output logic                              rx_valid,
  input  logic                              rx_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   tx_level,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   rx_level,
  output logic                              tx_underrun,
  output logic                              rx_overrun,
  output logic                              busy
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(WORD_W);
  localparam int unsigned LvlW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(WORD_W - 1);
  localparam logic [LvlW-1:0] LvlFull = LvlW'(FIFO_DEPTH);
  localparam logic SckIdle    = (CPOL != 0);
  localparam bit   SampleRise = (CPOL == CPHA);
  localparam bit   Cpha1      = (CPHA != 0);

  typedef enum logic [1:0] {StIdle, StLoad, StShift} state_e;

  logic [SYNC_STAGES-1:0] sck_sync_q, ssn_sync_q, mosi_sync_q;
  logic                   sck_prev_q, ssn_prev_q;
  logic                   sck_s, ssn_s, mosi_s;
  logic                   sample_edge, launch_edge, ssn_fall;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sck_sync_q  <= {SYNC_STAGES{SckIdle}};
      ssn_sync_q  <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= SckIdle;
      ssn_prev_q  <= 1'b1;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      ssn_sync_q  <= {ssn_sync_q[SYNC_STAGES-2:0], ssn};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sck_prev_q  <= sck_s;
      ssn_prev_q  <= ssn_s;
    end
  end

  assign sck_s       = sck_sync_q[SYNC_STAGES-1];
  assign ssn_s       = ssn_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign sample_edge = SampleRise ? (sck_s & ~sck_prev_q) : (~sck_s & sck_prev_q);
  assign launch_edge = SampleRise ? (~sck_s & sck_prev_q) : (sck_s & ~sck_prev_q);
  assign ssn_fall    = ~ssn_s & ssn_prev_q;

  logic [WORD_W-1:0] tx_mem_q [FIFO_DEPTH];
  logic [WORD_W-1:0] rx_mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   tx_wptr_q, tx_rptr_q, rx_wptr_q, rx_rptr_q;
  logic [LvlW-1:0]   tx_lvl_q, rx_lvl_q;
  logic              tx_push, tx_pop, rx_push, rx_pop, rx_push_req, tx_empty, rx_full;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WORD_W-1:0] tx_sh_q, tx_sh_d, load_word, rx_word;
  logic [WORD_W-2:0] rx_sh_q, rx_sh_d;
  logic              miso_q, miso_d, underrun_q, underrun_d, overrun_q;

  assign tx_empty = (tx_lvl_q == '0);
  assign rx_full  = (rx_lvl_q == LvlFull);
  assign tx_ready = (tx_lvl_q != LvlFull);
  assign tx_push  = tx_valid & tx_ready;
  assign rx_valid = (rx_lvl_q != '0);
  assign rx_pop   = rx_valid & rx_ready;
  assign rx_word  = {rx_sh_q, mosi_s};
  // A completed word is dropped when RX is full; a same-cycle pop does not make room.
  assign rx_push  = rx_push_req & ~rx_full;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tx_sh_d     = tx_sh_q;
    rx_sh_d     = rx_sh_q;
    miso_d      = miso_q;
    load_word   = '0;
    tx_pop      = 1'b0;
    rx_push_req = 1'b0;
    underrun_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        miso_d = 1'b0;
        cnt_d  = '0;
        if (ssn_fall) state_d = StLoad;
      end
      StLoad: begin
        tx_pop     = ~tx_empty;
        underrun_d = tx_empty;
        load_word  = tx_empty ? '0 : tx_mem_q[tx_rptr_q];
        cnt_d      = '0;
        if (Cpha1) begin
          tx_sh_d = load_word;
        end else begin
          miso_d  = load_word[WORD_W-1];
          tx_sh_d = load_word << 1;
        end
        state_d = StShift;
      end
      StShift: begin
        // CPHA=0: the trailing edge after a word's last sample must not advance the next word.
        if (launch_edge && (Cpha1 || (cnt_q != '0))) begin
          miso_d  = tx_sh_q[WORD_W-1];
          tx_sh_d = tx_sh_q << 1;
        end
        if (sample_edge) begin
          rx_sh_d = rx_word[WORD_W-2:0];
          if (cnt_q == CntLast) begin
            rx_push_req = 1'b1;
            cnt_d       = '0;
            state_d     = StLoad;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (ssn_s) begin
      state_d     = StIdle;
      miso_d      = 1'b0;
      cnt_d       = '0;
      tx_pop      = 1'b0;
      rx_push_req = 1'b0;
      underrun_d  = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      miso_q     <= 1'b0;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      tx_lvl_q   <= '0;
      rx_lvl_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      miso_q     <= miso_d;
      underrun_q <= underrun_d;
      overrun_q  <= rx_push_req & rx_full;
      if (tx_push) tx_wptr_q <= tx_wptr_q + PtrW'(1);
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + PtrW'(1);
      if (rx_push) rx_wptr_q <= rx_wptr_q + PtrW'(1);
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + PtrW'(1);
      if (tx_push && !tx_pop) tx_lvl_q <= tx_lvl_q + LvlW'(1);
      else if (!tx_push && tx_pop) tx_lvl_q <= tx_lvl_q - LvlW'(1);
      if (rx_push && !rx_pop) rx_lvl_q <= rx_lvl_q + LvlW'(1);
      else if (!rx_push && rx_pop) rx_lvl_q <= rx_lvl_q - LvlW'(1);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (tx_push) tx_mem_q[tx_wptr_q] <= tx_data;
    if (rx_push) rx_mem_q[rx_wptr_q] <= rx_word;
  end

  assign rx_data     = rx_mem_q[rx_rptr_q];
  assign tx_level    = tx_lvl_q;
  assign rx_level    = rx_lvl_q;
  assign miso        = miso_q;
  assign miso_oeb    = ssn_s;
  assign busy        = ~ssn_s;
  assign tx_underrun = underrun_q;
  assign rx_overrun  = overrun_q;

endmodule
